// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: request/grant arbiter sharing one single-port synchronous
// memory between the multicycle CPU and the DDU debug unit.
// Grants are combinational in the request cycle; read data returns one cycle
// later to the requester that issued the read, tagged by a registered owner bit.
// Optional build macro: MEM_ARB_RR_EN selects round-robin arbitration;
// when undefined, the CPU has fixed priority with a DDU starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ddu_req,
    input  logic              ddu_we,
    input  logic [ADDR_W-1:0] ddu_addr,
    input  logic [DATA_W-1:0] ddu_wdata,
    output logic              ddu_gnt,
    output logic              ddu_rvalid,
    output logic [DATA_W-1:0] ddu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  contention_cnt
);

    typedef enum logic {OWN_CPU = 1'b0, OWN_DDU = 1'b1} owner_t;

    logic             w_contend;
    logic             w_ddu_sel;
    logic             w_cpu_gnt;
    logic             w_ddu_gnt;
    logic             w_rd_issue;
    logic             r_rd_valid;
    owner_t           r_rd_owner;
    logic [CNT_W-1:0] r_cont_cnt;

`ifdef MEM_ARB_RR_EN
    owner_t r_pri_ptr;
`else
    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    logic [SW-1:0] r_starve_cnt;
`endif

    // Pick the winner for this cycle; reset suppresses every grant
    always_comb begin
        w_contend = cpu_req & ddu_req;
`ifdef MEM_ARB_RR_EN
        w_ddu_sel = w_contend ? (r_pri_ptr == OWN_CPU) : ddu_req;
`else
        w_ddu_sel = w_contend ? (r_starve_cnt == STARVE_LIM) : ddu_req;
`endif
        w_cpu_gnt  = ~rst & cpu_req & ~w_ddu_sel;
        w_ddu_gnt  = ~rst & ddu_req &  w_ddu_sel;
        w_rd_issue = (w_cpu_gnt & ~cpu_we) | (w_ddu_gnt & ~ddu_we);
    end

    // Steer the winner's access onto the memory port, zero when idle
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_ddu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ddu_we;
            mem_addr  = ddu_addr;
            mem_wdata = ddu_wdata;
        end
    end

    // Route returning read data only to the requester that owns it
    always_comb begin
        cpu_gnt        = w_cpu_gnt;
        ddu_gnt        = w_ddu_gnt;
        cpu_rvalid     = r_rd_valid & (r_rd_owner == OWN_CPU);
        ddu_rvalid     = r_rd_valid & (r_rd_owner == OWN_DDU);
        cpu_rdata      = cpu_rvalid ? mem_rdata : '0;
        ddu_rdata      = ddu_rvalid ? mem_rdata : '0;
        contention_cnt = r_cont_cnt;
    end

    // One-deep read pipeline: valid plus owner tag for the read granted last cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_owner <= OWN_CPU;
        end else begin
            r_rd_valid <= w_rd_issue;
            r_rd_owner <= w_ddu_gnt ? OWN_DDU : OWN_CPU;
        end
    end

    // Saturating count of cycles where both requesters asked at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cont_cnt <= '0;
        end else if (w_contend && (r_cont_cnt != '1)) begin
            r_cont_cnt <= r_cont_cnt + 1'b1;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember the last winner so contention alternates between requesters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pri_ptr <= OWN_CPU;
        end else if (w_cpu_gnt) begin
            r_pri_ptr <= OWN_CPU;
        end else if (w_ddu_gnt) begin
            r_pri_ptr <= OWN_DDU;
        end
    end
`else
    // Count contested CPU wins; forgiven once the DDU is served or goes idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_ddu_gnt || !ddu_req) begin
            r_starve_cnt <= '0;
        end else if (w_contend) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`endif

endmodule
